// File: rtl/ifetch_prefetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, default reset vector and prefetch entry layout.
package ifetch_prefetch_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a written entry is visible the next cycle.
// Push and pop may coincide; a push into a full FIFO without a pop is dropped (callers use credits).
module ifetch_prefetch_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch stage with prefetch FIFO: first instruction appears 2 cycles after the first granted request.
// Issue is throttled by in-flight + buffered credits; decode stalls via instr_ready_i; redirect flushes.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pc_incr_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic            fetch_en;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] push_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    push_dat;
  fetch_entry_t    pop_dat;

  // Every issued read owns a FIFO slot until popped, so the FIFO can never overflow.
  assign imem_req_o  = fetch_en && (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
  assign imem_addr_o = fetch_pc;
  assign issue       = imem_req_o && imem_gnt_i;
  assign target_pc   = word_align(redirect_pc_i);

  assign outstanding_nxt = outstanding + {{(CW-1){1'b0}}, issue}
                                       - {{(CW-1){1'b0}}, imem_rvalid_i};

  assign push     = imem_rvalid_i && !redirect_i && (discard == '0);
  assign pop      = instr_valid_o && instr_ready_i && !redirect_i;
  assign push_dat = '{pc: push_pc, instr: imem_rdata_i};

  ifetch_prefetch_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_i),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .count    (fifo_count)
  );

  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = instr_valid_o ? pop_dat.instr : '0;
  assign pc_o          = instr_valid_o ? pop_dat.pc    : '0;
  assign pc_incr_o     = pc_o + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_en    <= 1'b0;
      fetch_pc    <= RESET_PC;
      push_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_en    <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= target_pc;
        push_pc  <= target_pc;
        // whatever is still in flight after this cycle belongs to the old path
        discard  <= outstanding_nxt;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  push_pc  <= push_pc + 32'd4;
        if (imem_rvalid_i && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order memory model returning rdata = address.
module tb_ifetch_prefetch;
  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_incr_o;

  ifetch_prefetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_incr_o     (pc_incr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;

  rsp_t        pend[$];
  int unsigned cyc;
  int unsigned lat;
  logic        gnt_en;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory side at the negedge, record handshakes, return at the next negedge.
  task automatic step();
    logic        hs;
    logic        rv;
    logic [31:0] a;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_gnt_i    = gnt_en;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? pend[0].addr : 32'h0;
    #1;
    hs = imem_req_o && imem_gnt_i;
    a  = imem_addr_o;
    @(posedge clk);
    if (rv) void'(pend.pop_front());
    if (hs) pend.push_back('{addr: a, due: cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend.delete();
    redirect_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; lat = 1; gnt_en = 1'b1;
    rst_n = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc_incr", pc_incr_o, 32'h4);
    rst_n = 1'b1;
    step();
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, 32'h0);

    // Zero-wait streaming
    instr_ready_i = 1'b1;
    step();
    chk("t1_lat_valid", instr_valid_o, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_valid", instr_valid_o, 1);
      chk("t1_pc", pc_o, 32'(4 * i));
      chk("t1_instr", instr_o, 32'(4 * i));
      chk("t1_pc_incr", pc_incr_o, 32'(4 * i + 4));
    end

    // Decode stall: FIFO fills to 4 (28..40), request stops
    instr_ready_i = 1'b0;
    repeat (10) step();
    chk("t2_req_off", imem_req_o, 0);
    chk("t2_addr", imem_addr_o, 32'd44);
    chk("t2_hold_valid", instr_valid_o, 1);
    chk("t2_hold_pc", pc_o, 32'd28);
    instr_ready_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t2_valid", instr_valid_o, 1);
      chk("t2_pc", pc_o, 32'(28 + 4 * k));
    end

    // Latency 3, redirect with three reads in flight
    lat = 3;
    do_reset();
    step();
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    chk("t3_req", imem_req_o, 1);
    chk("t3_addr", imem_addr_o, 32'h100);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_stale_dropped", instr_valid_o, 0);
    end
    step();
    chk("t3_valid", instr_valid_o, 1);
    chk("t3_pc", pc_o, 32'h100);
    chk("t3_instr", instr_o, 32'h100);
    step();
    chk("t3_pc_next", pc_o, 32'h104);

    // Redirect coinciding with pop and rvalid, misaligned target
    lat = 1;
    do_reset();
    repeat (3) step();
    chk("t4_pre_pc", pc_o, 32'h4);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    chk("t4_valid_off", instr_valid_o, 0);
    chk("t4_addr", imem_addr_o, 32'h100);
    step();
    chk("t4_valid_off2", instr_valid_o, 0);
    step();
    chk("t4_valid", instr_valid_o, 1);
    chk("t4_pc", pc_o, 32'h100);
    chk("t4_instr", instr_o, 32'h100);
    chk("t4_pc_incr", pc_incr_o, 32'h104);
    step();
    chk("t4_pc_next", pc_o, 32'h104);

    // Grant withheld for three cycles
    gnt_en = 1'b0;
    step();
    chk("t5_req_g1", imem_req_o, 1);
    chk("t5_addr_g1", imem_addr_o, 32'h10C);
    chk("t5_pc_g1", pc_o, 32'h108);
    step();
    chk("t5_req_g2", imem_req_o, 1);
    chk("t5_addr_g2", imem_addr_o, 32'h10C);
    chk("t5_valid_g2", instr_valid_o, 0);
    step();
    chk("t5_req_g3", imem_req_o, 1);
    chk("t5_addr_g3", imem_addr_o, 32'h10C);
    gnt_en = 1'b1;
    step();
    chk("t5_addr_adv", imem_addr_o, 32'h110);
    step();
    chk("t5_valid", instr_valid_o, 1);
    chk("t5_pc", pc_o, 32'h10C);

    // Asynchronous reset mid-stream, then redirect to the top of the address space
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", instr_valid_o, 0);
    chk("t6_async_req", imem_req_o, 0);
    chk("t6_async_addr", imem_addr_o, 32'h0);
    chk("t6_async_pc", pc_o, 32'h0);
    chk("t6_async_pc_incr", pc_incr_o, 32'h4);
    @(negedge clk);
    pend.delete();
    rst_n = 1'b1;
    step();
    chk("t6_restart_req", imem_req_o, 1);
    chk("t6_restart_addr", imem_addr_o, 32'h0);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("t6_addr_wrap", imem_addr_o, 32'h0);
    chk("t6_valid_off", instr_valid_o, 0);
    step();
    chk("t6_valid", instr_valid_o, 1);
    chk("t6_pc", pc_o, 32'hFFFF_FFFC);
    chk("t6_instr", instr_o, 32'hFFFF_FFFC);
    chk("t6_pc_incr", pc_incr_o, 32'h0);
    step();
    chk("t6_pc_wrap", pc_o, 32'h0);
    chk("t6_pc_incr_wrap", pc_incr_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
